// File: rtl/seg7_disp_regs.sv
// ---------------------------------------------------------------------------
// seg7_disp_regs
// Memory-mapped register block feeding the 8-digit 7-segment scan driver.
// The CPU stages a 64-bit display word plus a mode bit. A commit write
// copies both into the committed registers in a single cycle, so the driver
// never shows a half-updated value. An optional blink function blanks the
// display periodically by forcing raw mode with every segment off.
//
// Ports:
//   clk        in   1   system clock
//   rstn       in   1   asynchronous active-low reset
//   bus_we     in   1   write strobe
//   bus_re     in   1   read strobe
//   bus_addr   in   2   word offset: 0=STAGE_LO 1=STAGE_HI 2=CTRL 3=STATUS
//   bus_wdata  in  32   write data
//   bus_wstrb  in   4   byte enables for writes
//   bus_rdata  out 32   registered read data
//   bus_rvalid out  1   read data valid, one-cycle pulse
//   disp_data  out 64   display word to the scan driver
//   disp_mode  out  1   0 = hex mode, 1 = raw segment mode
// ---------------------------------------------------------------------------
module seg7_disp_regs #(
    parameter int BLINK_DIV = 25000000,
    parameter int CNT_W     = 25
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wstrb,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic [63:0] disp_data,
    output logic        disp_mode
);

    localparam logic [1:0] ADDR_STAGE_LO = 2'd0;
    localparam logic [1:0] ADDR_STAGE_HI = 2'd1;
    localparam logic [1:0] ADDR_CTRL     = 2'd2;
    localparam logic [1:0] ADDR_STATUS   = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]      stage_lo_q, stage_lo_d;
    logic [31:0]      stage_hi_q, stage_hi_d;
    logic             ctrl_mode_q, ctrl_mode_d;
    logic             blink_en_q, blink_en_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_phase_q, blink_phase_d;
    logic [7:0]       commit_cnt_q, commit_cnt_d;
    logic [63:0]      com_data_q, com_data_d;
    logic             com_mode_q, com_mode_d;
    logic [63:0]      disp_data_q, disp_data_d;
    logic             disp_mode_q, disp_mode_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             commit_s;

    // Next-state logic for bus registers, commit, blink timer and outputs.
    always_comb begin
        stage_lo_d    = stage_lo_q;
        stage_hi_d    = stage_hi_q;
        ctrl_mode_d   = ctrl_mode_q;
        blink_en_d    = blink_en_q;
        commit_cnt_d  = commit_cnt_q;
        com_data_d    = com_data_q;
        com_mode_d    = com_mode_q;
        commit_s      = 1'b0;

        if (bus_we) begin
            case (bus_addr)
                ADDR_STAGE_LO: stage_lo_d = merge_bytes(stage_lo_q, bus_wdata, bus_wstrb);
                ADDR_STAGE_HI: stage_hi_d = merge_bytes(stage_hi_q, bus_wdata, bus_wstrb);
                ADDR_CTRL: begin
                    if (bus_wstrb[0]) begin
                        ctrl_mode_d = bus_wdata[0];
                        blink_en_d  = bus_wdata[1];
                    end else begin
                        ctrl_mode_d = ctrl_mode_q;
                        blink_en_d  = blink_en_q;
                    end
                    commit_s = bus_wstrb[1] & bus_wdata[8];
                end
                default: begin
                    // STATUS is read-only
                    commit_s = 1'b0;
                end
            endcase
        end else begin
            commit_s = 1'b0;
        end

        // Commit uses the merged mode from this same write.
        if (commit_s) begin
            com_data_d   = {stage_hi_q, stage_lo_q};
            com_mode_d   = ctrl_mode_d;
            commit_cnt_d = commit_cnt_q + 8'd1;
        end else begin
            com_data_d   = com_data_q;
            com_mode_d   = com_mode_q;
            commit_cnt_d = commit_cnt_q;
        end

        if (blink_en_q) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d   = {CNT_W{1'b0}};
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                blink_phase_d = blink_phase_q;
            end
        end else begin
            blink_cnt_d   = {CNT_W{1'b0}};
            blink_phase_d = 1'b0;
        end

        if (blink_en_q && blink_phase_q) begin
            disp_data_d = 64'hFFFF_FFFF_FFFF_FFFF;
            disp_mode_d = 1'b1;
        end else begin
            disp_data_d = com_data_q;
            disp_mode_d = com_mode_q;
        end

        // Reads see the state after any simultaneous write.
        rvalid_d = bus_re;
        if (bus_re) begin
            case (bus_addr)
                ADDR_STAGE_LO: rdata_d = stage_lo_d;
                ADDR_STAGE_HI: rdata_d = stage_hi_d;
                ADDR_CTRL:     rdata_d = {30'd0, blink_en_d, ctrl_mode_d};
                ADDR_STATUS:   rdata_d = {16'd0, commit_cnt_d, 7'd0, blink_phase_d};
                default:       rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_lo_q    <= 32'd0;
            stage_hi_q    <= 32'd0;
            ctrl_mode_q   <= 1'b0;
            blink_en_q    <= 1'b0;
            blink_cnt_q   <= {CNT_W{1'b0}};
            blink_phase_q <= 1'b0;
            commit_cnt_q  <= 8'd0;
            com_data_q    <= 64'd0;
            com_mode_q    <= 1'b0;
            disp_data_q   <= 64'd0;
            disp_mode_q   <= 1'b0;
            rdata_q       <= 32'd0;
            rvalid_q      <= 1'b0;
        end else begin
            stage_lo_q    <= stage_lo_d;
            stage_hi_q    <= stage_hi_d;
            ctrl_mode_q   <= ctrl_mode_d;
            blink_en_q    <= blink_en_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            commit_cnt_q  <= commit_cnt_d;
            com_data_q    <= com_data_d;
            com_mode_q    <= com_mode_d;
            disp_data_q   <= disp_data_d;
            disp_mode_q   <= disp_mode_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign disp_data  = disp_data_q;
    assign disp_mode  = disp_mode_q;

endmodule

// File: tb/tb_seg7_disp_regs.sv
// Directed bench for seg7_disp_regs with a short blink period (BLINK_DIV=4).
module tb_seg7_disp_regs;

    logic        clk;
    logic        rstn;
    logic        bus_we;
    logic        bus_re;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [63:0] disp_data;
    logic        disp_mode;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] COM2 = 64'h00BB_00DD_1234_5678;

    seg7_disp_regs #(.BLINK_DIV(4), .CNT_W(3)) dut (
        .clk(clk), .rstn(rstn),
        .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .disp_data(disp_data), .disp_mode(disp_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n edges and settle 1ns past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d; bus_wstrb = s;
        @(posedge clk);
        #1;
        bus_we = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus_re = 1'b1; bus_addr = a;
        @(posedge clk);
        #1;
        bus_re = 1'b0;
        check({tag, "_rvalid"}, {63'd0, bus_rvalid}, 64'd1);
        check(tag, {32'd0, bus_rdata}, {32'd0, exp});
    endtask

    initial begin
        rstn = 1'b0; bus_we = 1'b0; bus_re = 1'b0;
        bus_addr = 2'd0; bus_wdata = 32'd0; bus_wstrb = 4'd0;
        cyc(3);
        @(negedge clk);
        rstn = 1'b1;
        cyc(1);

        // Reset state
        check("rst_disp_data", disp_data, 64'd0);
        check("rst_disp_mode", {63'd0, disp_mode}, 64'd0);
        check("rst_rvalid", {63'd0, bus_rvalid}, 64'd0);
        rd_check("rst_status", 2'd3, 32'h0);
        cyc(1);
        check("rvalid_pulse", {63'd0, bus_rvalid}, 64'd0);

        // Staged update and commit
        wr(2'd0, 32'h1234_5678, 4'hF);
        cyc(2);
        check("stage_no_disp", disp_data, 64'd0);
        wr(2'd2, 32'h0000_0100, 4'h2);
        check("commit_latency", disp_data, 64'd0);
        cyc(1);
        check("commit_data", disp_data, 64'h0000_0000_1234_5678);
        check("commit_mode", {63'd0, disp_mode}, 64'd0);
        rd_check("status_cnt1", 2'd3, 32'h0000_0100);
        rd_check("ctrl_rd0", 2'd2, 32'h0);

        // Byte strobes and merged mode
        wr(2'd1, 32'hAABB_CCDD, 4'b0101);
        rd_check("stage_hi_strb", 2'd1, 32'h00BB_00DD);
        wr(2'd2, 32'h0000_0101, 4'b0011);
        cyc(1);
        check("merged_mode", {63'd0, disp_mode}, 64'd1);
        check("merged_data", disp_data, COM2);
        rd_check("status_cnt2", 2'd3, 32'h0000_0200);
        // Commit bit without byte-1 strobe must not commit
        wr(2'd2, 32'h0000_0100, 4'b0001);
        cyc(2);
        check("no_commit_mode", {63'd0, disp_mode}, 64'd1);
        rd_check("status_nocommit", 2'd3, 32'h0000_0200);

        // Blink: enable edge is E0; blank shows from E0+5 to E0+8
        wr(2'd2, 32'h0000_0002, 4'b0001);
        cyc(4);
        check("blink_on_pre", disp_data, COM2);
        cyc(1);
        check("blink_blank_data", disp_data, ONES);
        check("blink_blank_mode", {63'd0, disp_mode}, 64'd1);
        cyc(3);
        check("blink_blank_end", disp_data, ONES);
        cyc(1);
        check("blink_restore", disp_data, COM2);
        cyc(4);
        check("blink_blank2", disp_data, ONES);
        // Clear blink_en during blank phase
        wr(2'd2, 32'h0000_0000, 4'b0001);
        check("clear_still_blank", disp_data, ONES);
        cyc(1);
        check("clear_restore", disp_data, COM2);
        rd_check("status_phase0", 2'd3, 32'h0000_0200);

        // Commit counter wrap: 2 so far, 254 more -> 256 -> 0
        wr(2'd2, 32'h0000_0001, 4'b0001);
        for (int i = 0; i < 254; i++) begin
            wr(2'd2, 32'h0000_0100, 4'b0010);
        end
        rd_check("status_wrap", 2'd3, 32'h0);
        rd_check("ctrl_commit_rd0", 2'd2, 32'h0000_0001);

        // Async reset mid-blink
        wr(2'd0, 32'hCAFE_F00D, 4'hF);
        wr(2'd2, 32'h0000_0103, 4'b0011);
        cyc(2);
        check("pre_rst_data", disp_data, 64'h00BB_00DD_CAFE_F00D);
        #1;
        rstn = 1'b0;
        #1;
        check("async_rst_data", disp_data, 64'd0);
        check("async_rst_mode", {63'd0, disp_mode}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        rd_check("post_rst_stage_lo", 2'd0, 32'h0);
        rd_check("post_rst_status", 2'd3, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
